// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: tester-side load / capture / unload master for a mux-scan chain.
// Define SCAN_COMPARE_EN for masked response compare; the compare input is named
// 'expected' because 'expect' is a reserved word.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN      = 3,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
`ifdef SCAN_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic [CHAIN_LEN-1:0] mask,
  output logic                 fail,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 test_se,
  output logic                 test_si,
  input  logic                 test_so
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [3:0] CAP_LAST = 4'(CAPTURE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t               state;
  logic [CHAIN_LEN-1:0] shreg;
  logic [CW-1:0]        cnt;
  logic [3:0]           cap_cnt;

  // One register serves both directions: LOAD drains its MSB,
  // UNLOAD fills it from the LSB side.
  function automatic logic [CHAIN_LEN-1:0] shl(
    input logic [CHAIN_LEN-1:0] v,
    input logic                 b
  );
    return (v << 1) | CHAIN_LEN'(b);
  endfunction

  // Sequencer: load pattern, capture, unload response, pulse done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      test_se  <= 1'b0;
      test_si  <= 1'b0;
      response <= '0;
      shreg    <= '0;
      cnt      <= '0;
      cap_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD;
            busy    <= 1'b1;
            test_se <= 1'b1;
            test_si <= pattern[CHAIN_LEN-1];
            shreg   <= pattern << 1;
            cnt     <= CNT_LAST;
          end
        end
        S_LOAD: begin
          if (cnt == '0) begin
            state   <= S_CAPTURE;
            test_se <= 1'b0;
            test_si <= 1'b0;
            cap_cnt <= CAP_LAST;
          end else begin
            test_si <= shreg[CHAIN_LEN-1];
            shreg   <= shreg << 1;
            cnt     <= cnt - 1'b1;
          end
        end
        S_CAPTURE: begin
          if (cap_cnt == '0) begin
            state   <= S_UNLOAD;
            test_se <= 1'b1;
            test_si <= 1'b0;
            cnt     <= CNT_LAST;
          end else begin
            cap_cnt <= cap_cnt - 1'b1;
          end
        end
        S_UNLOAD: begin
          shreg <= shl(shreg, test_so);
          if (cnt == '0) begin
            state    <= S_DONE;
            test_se  <= 1'b0;
            done     <= 1'b1;
            response <= shl(shreg, test_so);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SCAN_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;

  // Latch compare operands at acceptance; judge the response as it completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q  <= '0;
      mask_q <= '0;
      fail   <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        exp_q  <= expected;
        mask_q <= mask;
      end
      if (state == S_UNLOAD && cnt == '0) begin
        fail <= |((shl(shreg, test_so) ^ exp_q) & mask_q);
      end
    end
  end
`endif

endmodule
